prog_rom: RTL
=============

Name: prog_rom

Overview:
- Parametrised successor to the fixed-size bus ROM: a memory-mapped ROM on the shared read/write address buses, with configurable width, depth, base address and read latency.
- Replaces the raw write_protect pin with a keyed unlock state machine for in-system programming, plus an idle auto-relock timer.
- Sits on the system bus beside RAM/IO. The top level owns the tri-state data bus; this block exposes data_out/data_oe.

Parameters:
- WIDTH, 16, data word width in bits
- ADDR_W, 16, address bus width
- DEPTH, 32768, number of words (power of two, ≤ 2^ADDR_W)
- BASE, 16'h8000, first bus address of the array; the array spans BASE..BASE+DEPTH-1
- CTRL_ADDR, 16'h7FFE, control/status register address; must lie outside the array range
- KEY_A, 16'hA55A, first unlock key
- KEY_B, 16'h5AA5, second unlock key
- READ_LAT, 1, read latency in cycles (1 or 2)
- TIMEOUT, 256, idle cycles in UNLOCKED before auto-relock

Ports:
- clk  in  1  system clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- read_addr  in  ADDR_W  read bus address
- read_req  in  1  read strobe, one cycle
- write_addr  in  ADDR_W  write bus address
- write_req  in  1  write strobe, one cycle
- data_in  in  WIDTH  write data from the bus
- write_protect  in  1  hard lock; when high, forces LOCKED
- data_out  out  WIDTH  read data
- data_oe  out  1  drive enable for the bus tri-state
- unlocked  out  1  high in UNLOCKED
- write_fault  out  1  sticky; set by an array write while not UNLOCKED

Behaviour:
- Reset values: data_out=0, data_oe=0, unlocked=0, write_fault=0, state=LOCKED, idle counter=0. Array contents are not reset.
- Address decode: in_range = (addr >= BASE) && (addr - BASE < DEPTH). The subtraction is done at ADDR_W bits with no wrap-around aliasing. The array index is addr - BASE, truncated to log2(DEPTH) bits.
- Array read: read_req with in-range read_addr loads the array word. data_out and data_oe=1 become valid READ_LAT cycles after the request.
  - With READ_LAT=2, there is one internal pipeline register. Back-to-back requests are accepted every cycle.
- CTRL read: read_req at CTRL_ADDR returns a status word {write_fault, unlocked, 0...} in the top two bits, with the same latency.
- data_oe clears one cycle after either of:
  - write_req (any address), or
  - read_req to an address that is neither in range nor CTRL_ADDR.
- data_oe otherwise holds its value, so data_out is held for a multi-cycle bus read.
- Simultaneous read and write to the same array word: the read returns the old data, and write_req's oe-clear takes priority over the pending read output.
- State machine (CTRL writes are write_req at CTRL_ADDR):
  - LOCKED → KEY1: CTRL write of KEY_A.
  - KEY1 → UNLOCKED: CTRL write of KEY_B.
  - KEY1 → LOCKED: any other CTRL write, or any array write.
  - UNLOCKED → LOCKED: any CTRL write of any value, or TIMEOUT consecutive cycles with no write_req.
  - Any state → LOCKED: write_protect=1, checked every cycle, highest priority after reset.
- Array write: write_req with in-range write_addr.
  - In UNLOCKED: stores data_in and clears the idle counter.
  - Otherwise: data is discarded and write_fault is set.
- write_fault clears only on reset, or on a CTRL write of KEY_A while LOCKED (that write also advances to KEY1).
- Idle counter: width clog2(TIMEOUT+1). Counts only in UNLOCKED, saturates at TIMEOUT, resets on any write_req.
- unlocked is registered; it asserts the cycle after the KEY_B write.
- Reset asserted mid-sequence or mid-read: returns to LOCKED and drops data_oe the next cycle. Any in-flight pipeline read is discarded.

Optional Feature:
- Macro: PROG_ROM_PARITY_EN.
- Defined:
  - The array stores WIDTH+1 bits per word: even parity generated on write.
  - Parity is checked on array reads when the data is presented.
  - A mismatch sets a sticky parity_err output port (reset 0) and forces data_out to all-ones for that read.
  - CTRL status bit WIDTH-3 mirrors parity_err.
  - A CTRL write of 0 while LOCKED clears parity_err.
- Undefined: no parity storage, no parity_err port, and status bit WIDTH-3 reads 0.

Test Plan:
- Reset, then read_req @8000 with preloaded array[0]=16'h1234, READ_LAT=1 → next cycle data_oe=1, data_out=16'h1234. Then read_req @0010 → data_oe=0 the next cycle.
- Locked write @8005 of 16'hBEEF → array[5] unchanged, write_fault=1. CTRL write A55A then 5AA5 → unlocked=1. Write @8005 of BEEF, then read @8005 → BEEF.
- Wrong key: CTRL A55A then 1111 → state LOCKED, unlocked=0. A following write @8001 is ignored.
- Unlocked with no writes for 256 cycles → unlocked drops in cycle 257. Assert write_protect mid-UNLOCKED → unlocked=0 the next cycle.
- READ_LAT=2: read_req on three consecutive cycles @8000/8001/8002 → data appears on cycles +2/+3/+4 in order. Assert reset at +1 → data_oe stays 0.
- PROG_ROM_PARITY_EN: force-flip a stored bit, then read → data_out=16'hFFFF and parity_err=1. It stays 1 until a CTRL write of 0 while LOCKED.

Source files
------------

// File: rtl/prog_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prog_rom                                                      |
// | Purpose  : Memory-mapped programmable ROM on the shared read/write       |
// |            address buses. Writes to the array are gated by a keyed       |
// |            unlock state machine (KEY_A then KEY_B written to CTRL_ADDR)  |
// |            with an idle auto-relock timer. The top level owns the        |
// |            tri-state data bus; this block exposes data_out/data_oe.      |
// | Ports    : clk, reset (sync, active high)                                |
// |            read_addr/read_req   - read bus address and one-cycle strobe  |
// |            write_addr/write_req - write bus address and one-cycle strobe |
// |            data_in              - write data                             |
// |            write_protect        - hard lock, forces LOCKED               |
// |            data_out/data_oe     - read data and bus drive enable         |
// |            unlocked             - high while UNLOCKED                    |
// |            write_fault          - sticky, array write while not UNLOCKED |
// |            parity_err           - sticky parity error (macro only)       |
// | Macro    : PROG_ROM_PARITY_EN adds per-word even parity and parity_err.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module prog_rom #(
    parameter int                WIDTH     = 16,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 32768,
    parameter logic [ADDR_W-1:0] BASE      = 16'h8000,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 16'h7FFE,
    parameter logic [WIDTH-1:0]  KEY_A     = 16'hA55A,
    parameter logic [WIDTH-1:0]  KEY_B     = 16'h5AA5,
    parameter int                READ_LAT  = 1,
    parameter int                TIMEOUT   = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              read_req,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              write_req,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              write_protect,
    output logic [WIDTH-1:0]  data_out,
    output logic              data_oe,
    output logic              unlocked,
`ifdef PROG_ROM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              write_fault
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
`ifdef PROG_ROM_PARITY_EN
    localparam int MEM_W = WIDTH + 1;
`else
    localparam int MEM_W = WIDTH;
`endif
    localparam logic [ADDR_W:0]  C_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(TIMEOUT);

    localparam logic [1:0] C_KIND_OTHER = 2'd0;
    localparam logic [1:0] C_KIND_ARRAY = 2'd1;
    localparam logic [1:0] C_KIND_CTRL  = 2'd2;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_KEY1     = 2'd1,
        ST_UNLOCKED = 2'd2
    } state_t;

    // Subtraction is widened by one bit so addresses below BASE cannot wrap
    // around into the array window.
    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] diff;
        diff = {1'b0, a} - {1'b0, BASE};
        return (a >= BASE) && (diff < C_DEPTH_EXT);
    endfunction

    // ---------------------------------------------------------------- decode
    logic             w_ctrl_wr;
    logic             w_arr_wr;
    logic             w_wr_ok;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [1:0]       w_rd_kind;
    logic [MEM_W-1:0] w_wr_word;
    logic [MEM_W-1:0] w_rd_word;
    logic [WIDTH-1:0] w_status;

    state_t           r_state_q, w_state_d;
    logic [CNT_W-1:0] r_idle_q, w_idle_d;
    logic             r_unlocked_q, w_unlocked_d;
    logic             r_write_fault_q, w_write_fault_d;
    logic [WIDTH-1:0] r_data_out_q, w_data_out_d;
    logic             r_data_oe_q, w_data_oe_d;
`ifdef PROG_ROM_PARITY_EN
    logic             r_parity_err_q, w_parity_err_d;
`endif

    assign w_ctrl_wr = write_req && (write_addr == CTRL_ADDR);
    assign w_arr_wr  = write_req && f_in_range(write_addr);
    // write_protect takes effect in the same cycle it is seen.
    assign w_wr_ok   = w_arr_wr && (r_state_q == ST_UNLOCKED) && !write_protect;
    assign w_wr_idx  = IDX_W'(write_addr - BASE);
    assign w_rd_idx  = IDX_W'(read_addr - BASE);

`ifdef PROG_ROM_PARITY_EN
    assign w_wr_word = {^data_in, data_in};
`else
    assign w_wr_word = data_in;
`endif

    always_comb begin
        w_rd_kind = C_KIND_OTHER;
        if (f_in_range(read_addr)) begin
            w_rd_kind = C_KIND_ARRAY;
        end else if (read_addr == CTRL_ADDR) begin
            w_rd_kind = C_KIND_CTRL;
        end
    end

    always_comb begin
        w_status            = '0;
        w_status[WIDTH-1]   = r_write_fault_q;
        w_status[WIDTH-2]   = r_unlocked_q;
`ifdef PROG_ROM_PARITY_EN
        w_status[WIDTH-3]   = r_parity_err_q;
`endif
    end

    // ---------------------------------------------------------------- array
    logic [MEM_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_idx] <= w_wr_word;
        end
    end

    // Read sees pre-write contents when both strobes hit the same word.
    assign w_rd_word = r_mem[w_rd_idx];

    // ------------------------------------------------------- read pipeline
    // w_p_* is the read being presented to the output register this cycle.
    logic             w_p_valid;
    logic [1:0]       w_p_kind;
    logic [MEM_W-1:0] w_p_word;
    logic [WIDTH-1:0] w_p_status;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic             r_s1_valid_q, w_s1_valid_d;
            logic [1:0]       r_s1_kind_q;
            logic [MEM_W-1:0] r_s1_word_q;
            logic [WIDTH-1:0] r_s1_status_q;

            // A write in the same cycle as the request cancels that read.
            always_comb begin
                w_s1_valid_d = read_req && !write_req;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1_valid_q <= 1'b0;
                end else begin
                    r_s1_valid_q <= w_s1_valid_d;
                end
                r_s1_kind_q   <= w_rd_kind;
                r_s1_word_q   <= w_rd_word;
                r_s1_status_q <= w_status;
            end

            assign w_p_valid  = r_s1_valid_q;
            assign w_p_kind   = r_s1_kind_q;
            assign w_p_word   = r_s1_word_q;
            assign w_p_status = r_s1_status_q;
        end else begin : g_lat1
            assign w_p_valid  = read_req;
            assign w_p_kind   = w_rd_kind;
            assign w_p_word   = w_rd_word;
            assign w_p_status = w_status;
        end
    endgenerate

    // --------------------------------------------------------- output stage
    always_comb begin
        w_data_out_d = r_data_out_q;
        w_data_oe_d  = r_data_oe_q;
`ifdef PROG_ROM_PARITY_EN
        w_parity_err_d = r_parity_err_q;
        if (w_ctrl_wr && (data_in == '0) && (r_state_q == ST_LOCKED)) begin
            w_parity_err_d = 1'b0;
        end
`endif
        if (write_req) begin
            w_data_oe_d = 1'b0;
        end else if (w_p_valid) begin
            case (w_p_kind)
                C_KIND_ARRAY: begin
                    w_data_oe_d  = 1'b1;
                    w_data_out_d = w_p_word[WIDTH-1:0];
`ifdef PROG_ROM_PARITY_EN
                    if (^w_p_word) begin
                        w_data_out_d   = '1;
                        w_parity_err_d = 1'b1;
                    end
`endif
                end
                C_KIND_CTRL: begin
                    w_data_oe_d  = 1'b1;
                    w_data_out_d = w_p_status;
                end
                default: begin
                    w_data_oe_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------ unlock state machine
    always_comb begin
        w_idle_d = r_idle_q;
        if (write_req) begin
            w_idle_d = '0;
        end else if ((r_state_q == ST_UNLOCKED) && (r_idle_q != C_TIMEOUT)) begin
            w_idle_d = r_idle_q + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_LOCKED: begin
                if (w_ctrl_wr && (data_in == KEY_A)) begin
                    w_state_d = ST_KEY1;
                end
            end
            ST_KEY1: begin
                if (w_ctrl_wr) begin
                    w_state_d = (data_in == KEY_B) ? ST_UNLOCKED : ST_LOCKED;
                end else if (w_arr_wr) begin
                    w_state_d = ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                // Relock on the edge where the idle count reaches TIMEOUT.
                if (w_ctrl_wr || (!write_req && (w_idle_d == C_TIMEOUT))) begin
                    w_state_d = ST_LOCKED;
                end
            end
            default: begin
                w_state_d = ST_LOCKED;
            end
        endcase
        if (write_protect) begin
            w_state_d = ST_LOCKED;
        end
    end

    always_comb begin
        w_unlocked_d    = (w_state_d == ST_UNLOCKED);
        w_write_fault_d = r_write_fault_q;
        if (w_arr_wr && !w_wr_ok) begin
            w_write_fault_d = 1'b1;
        end else if (w_ctrl_wr && (data_in == KEY_A) && (r_state_q == ST_LOCKED)
                     && !write_protect) begin
            w_write_fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q       <= ST_LOCKED;
            r_idle_q        <= '0;
            r_unlocked_q    <= 1'b0;
            r_write_fault_q <= 1'b0;
            r_data_out_q    <= '0;
            r_data_oe_q     <= 1'b0;
`ifdef PROG_ROM_PARITY_EN
            r_parity_err_q  <= 1'b0;
`endif
        end else begin
            r_state_q       <= w_state_d;
            r_idle_q        <= w_idle_d;
            r_unlocked_q    <= w_unlocked_d;
            r_write_fault_q <= w_write_fault_d;
            r_data_out_q    <= w_data_out_d;
            r_data_oe_q     <= w_data_oe_d;
`ifdef PROG_ROM_PARITY_EN
            r_parity_err_q  <= w_parity_err_d;
`endif
        end
    end

    assign data_out    = r_data_out_q;
    assign data_oe     = r_data_oe_q;
    assign unlocked    = r_unlocked_q;
    assign write_fault = r_write_fault_q;
`ifdef PROG_ROM_PARITY_EN
    assign parity_err  = r_parity_err_q;
`endif

endmodule
`default_nettype wire
